// File: rtl/adi_spi_responder.sv
// adi_spi_responder: 3-wire SPI slave decoding 24-bit ADI frames into a small byte register file.
// All SPI pins are oversampled by Clock through 2-flop synchronisers.
module adi_spi_responder #(
    parameter int         ADDR_BITS   = 4,
    parameter logic [7:0] CHIP_ID     = 8'h8A,
    parameter logic [7:0] REG_DEFAULT = 8'h00
) (
    input  logic                 Clock,
    input  logic                 Reset_N,
    input  logic                 sclk,
    input  logic                 ss_n,
    inout  wire                  sdio,
    output logic                 Reg_Write_Enable,
    output logic [ADDR_BITS-1:0] Reg_Write_Addr,
    output logic [7:0]           Reg_Write_Data,
    output logic                 Frame_Error,
    output logic                 busy
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {IDLE, INSTR, DATA_WR, DATA_RD, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sclk_sync_q, ss_sync_q, sdi_sync_q;
    logic                 sclk_prev_q, ss_prev_q;
    logic [4:0]           cnt_q, cnt_d;
    logic [21:0]          sr_q, sr_d;
    logic [22:0]          sh;
    logic [7:0]           rd_q, rd_d, rd_val;
    logic                 sdo_q, sdo_d, oe_q, oe_d;
    logic                 we_q, we_d, fe_q, fe_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           regs_q [DEPTH];
    logic [7:0]           regs_d [DEPTH];
    logic                 sclk_rise, sclk_fall, ss_rise, ss_fall, wr_ok;
    logic [14:0]          ra, wa;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign ss_rise   = ss_sync_q[1] & ~ss_prev_q;
    assign ss_fall   = ~ss_sync_q[1] & ss_prev_q;
    // sh is the shift register as it will look after the current rise
    assign sh        = {sr_q, sdi_sync_q[1]};
    assign ra        = sh[14:0];
    assign wa        = sh[22:8];
    assign rd_val    = (ra == '0) ? CHIP_ID : (ra[14:ADDR_BITS] == '0) ? regs_q[ra[ADDR_BITS-1:0]] : 8'h00;
    assign wr_ok     = (wa != '0) && (wa[14:ADDR_BITS] == '0);

    // Release must not wait for the synchronisers, hence the raw ss_n/Reset_N gating
    assign sdio             = (oe_q & ~ss_n & Reset_N) ? sdo_q : 1'bz;
    assign busy             = state_q != IDLE;
    assign Reg_Write_Enable = we_q;
    assign Reg_Write_Addr   = waddr_q;
    assign Reg_Write_Data   = wdata_q;
    assign Frame_Error      = fe_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        rd_d    = rd_q;
        sdo_d   = sdo_q;
        oe_d    = oe_q;
        regs_d  = regs_q;
        we_d    = 1'b0;
        fe_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE) begin
            if (ss_fall) begin
                state_d = INSTR;
                cnt_d   = '0;
            end
        end else if (ss_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            fe_d    = state_q != DONE;
        end else begin
            if (sclk_rise) begin
                cnt_d = (cnt_q == 5'd24) ? cnt_q : cnt_q + 5'd1;
                if (state_q != DONE) sr_d = sh[21:0];
                if (state_q == INSTR && cnt_q == 5'd15) begin
                    state_d = sh[15] ? DATA_RD : DATA_WR;
                    rd_d    = rd_val;
                end
                if ((state_q == DATA_WR || state_q == DATA_RD) && cnt_q == 5'd23) begin
                    state_d = DONE;
                    if (state_q == DATA_WR && wr_ok) begin
                        we_d                         = 1'b1;
                        waddr_d                      = wa[ADDR_BITS-1:0];
                        wdata_d                      = sh[7:0];
                        regs_d[wa[ADDR_BITS-1:0]]    = sh[7:0];
                    end
                end
            end
            if (sclk_fall && state_q == DATA_RD) begin
                oe_d  = 1'b1;
                sdo_d = rd_q[7];
                rd_d  = {rd_q[6:0], 1'b0};
            end else if (sclk_fall && state_q == DONE) begin
                oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            rd_q        <= '0;
            sdo_q       <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            fe_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            regs_q      <= '{default: REG_DEFAULT};
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            ss_sync_q   <= {ss_sync_q[0], ss_n};
            sdi_sync_q  <= {sdi_sync_q[0], sdio};
            sclk_prev_q <= sclk_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            rd_q        <= rd_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            fe_q        <= fe_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            regs_q      <= regs_d;
        end
    end
endmodule

// File: tb/tb_adi_spi_responder.sv
// tb_adi_spi_responder: SPI master model driving ADI frames against a byte-array reference model.
// sdio carries a pullup so a released line reads 1.
module tb_adi_spi_responder;
    logic       Clock = 1'b0;
    logic       Reset_N = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       m_oe = 1'b0;
    logic       m_do = 1'b0;
    wire        sdio;
    logic       Reg_Write_Enable, Frame_Error, busy;
    logic [3:0] Reg_Write_Addr;
    logic [7:0] Reg_Write_Data;

    int         n_chk = 0, n_fail = 0, we_cnt = 0, fe_cnt = 0;
    logic [7:0] mem [16];
    logic [3:0] exp_wa;
    logic [7:0] exp_wd;

    assign sdio = m_oe ? m_do : 1'bz;
    pullup (sdio);

    adi_spi_responder dut (
        .Clock(Clock), .Reset_N(Reset_N), .sclk(sclk), .ss_n(ss_n), .sdio(sdio),
        .Reg_Write_Enable(Reg_Write_Enable), .Reg_Write_Addr(Reg_Write_Addr),
        .Reg_Write_Data(Reg_Write_Data), .Frame_Error(Frame_Error), .busy(busy)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Reg_Write_Enable) we_cnt++;
        if (Frame_Error) fe_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [14:0] a);
        if (a == 0) return 8'h8A;
        if (a < 16) return mem[a[3:0]];
        return 8'h00;
    endfunction

    // One master frame; rst_at > 0 asserts Reset_N while the slave drives that read bit
    task automatic frame(input logic rw, input logic [14:0] a, input logic [7:0] d,
                         input int nclk, input int rst_at, output logic [7:0] rd);
        logic [23:0] f;
        f    = {rw, a, d};
        rd   = '0;
        ss_n = 1'b0;
        m_do = f[23];
        m_oe = 1'b1;
        #100;
        for (int i = 0; i < nclk; i++) begin
            if (i >= 16 && i < 24) rd = {rd[6:0], sdio};
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
            if (i + 1 < 24 && !(rw && i + 1 >= 16)) m_do = f[22 - i];
            else m_oe = 1'b0;
            if (rst_at > 0 && i + 1 == rst_at - 1) begin
                #40;
                check("rst_pre_drive", {15'd0, sdio}, 16'd0);
                Reset_N = 1'b0;
                #1;
                check("rst_sdio_release", {15'd0, sdio}, 16'd1);
                check("rst_busy", {15'd0, busy}, 16'd0);
                check("rst_we", {15'd0, Reg_Write_Enable}, 16'd0);
                return;
            end
            #50;
        end
        m_oe = 1'b0;
        if (nclk >= 24) check("sdio_release", {15'd0, sdio}, 16'd1);
        check("busy_in_frame", {15'd0, busy}, 16'd1);
        #100;
        ss_n = 1'b1;
        #200;
        check("busy_after", {15'd0, busy}, 16'd0);
    endtask

    task automatic xfer(input logic rw, input logic [14:0] a, input logic [7:0] d,
                        input int nclk, input string tag);
        int         we0, fe0;
        logic [7:0] rd;
        logic       ok_w;
        we0  = we_cnt;
        fe0  = fe_cnt;
        ok_w = !rw && nclk >= 24 && a != 0 && a < 16;
        frame(rw, a, d, nclk, 0, rd);
        if (rw && nclk >= 24) check({tag, "_rdata"}, {8'd0, rd}, {8'd0, model_rd(a)});
        check({tag, "_we"}, 16'(we_cnt - we0), {15'd0, ok_w});
        check({tag, "_fe"}, 16'(fe_cnt - fe0), (nclk < 24) ? 16'd1 : 16'd0);
        if (ok_w) begin
            mem[a[3:0]] = d;
            exp_wa      = a[3:0];
            exp_wd      = d;
        end
        check({tag, "_waddr"}, {12'd0, Reg_Write_Addr}, {12'd0, exp_wa});
        check({tag, "_wdata"}, {8'd0, Reg_Write_Data}, {8'd0, exp_wd});
    endtask

    initial begin
        logic [7:0]  rd;
        logic [14:0] a;
        int          we0, fe0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        exp_wa = '0;
        exp_wd = '0;
        #30;
        check("reset_we", {15'd0, Reg_Write_Enable}, 16'd0);
        check("reset_fe", {15'd0, Frame_Error}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_waddr", {12'd0, Reg_Write_Addr}, 16'd0);
        check("reset_wdata", {8'd0, Reg_Write_Data}, 16'd0);
        check("reset_sdio", {15'd0, sdio}, 16'd1);
        Reset_N = 1'b1;
        #200;

        xfer(1'b0, 15'h0005, 8'hA5, 24, "wr5");
        xfer(1'b1, 15'h0005, 8'h00, 24, "rd5");
        xfer(1'b1, 15'h0000, 8'h00, 24, "rd0");
        xfer(1'b0, 15'h0000, 8'h55, 24, "wr0");
        xfer(1'b1, 15'h0000, 8'h00, 24, "rd0_again");
        xfer(1'b0, 15'h0003, 8'h77, 10, "abort3");
        xfer(1'b1, 15'h0003, 8'h00, 24, "rd3");
        xfer(1'b0, 15'h0100, 8'hFF, 24, "wr_oor");
        xfer(1'b1, 15'h0100, 8'h00, 24, "rd_oor");
        xfer(1'b1, 15'h0000, 8'h00, 24, "rd0_oor");
        xfer(1'b0, 15'h0007, 8'h3C, 24, "wr7");
        xfer(1'b1, 15'h0007, 8'h00, 30, "rd7_long");

        for (int k = 0; k < 20; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(16, 32767)) : 15'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(24, 27), "rand");
        end

        xfer(1'b0, 15'h0002, 8'h00, 24, "wr2_zero");
        xfer(1'b0, 15'h0005, 8'hA5, 24, "wr5_again");
        we0 = we_cnt;
        fe0 = fe_cnt;
        frame(1'b1, 15'h0002, 8'h00, 24, 20, rd);
        m_oe = 1'b0;
        ss_n = 1'b1;
        #9;
        #50;
        Reset_N = 1'b1;
        #200;
        check("rst_no_we", 16'(we_cnt - we0), 16'd0);
        check("rst_no_fe", 16'(fe_cnt - fe0), 16'd0);
        check("rst_busy_after", {15'd0, busy}, 16'd0);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        exp_wa = '0;
        exp_wd = '0;
        xfer(1'b1, 15'h0005, 8'h00, 24, "post_rst_rd5");
        xfer(1'b1, 15'h0000, 8'h00, 24, "post_rst_rd0");
        xfer(1'b0, 15'h0004, 8'h96, 24, "post_rst_wr4");
        xfer(1'b1, 15'h0004, 8'h00, 24, "post_rst_rd4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
